// File: rtl/serial_subtractor_pkg.sv
// Shared types for the bit-serial subtractor: FSM encoding and counter sizing.
package serial_arith_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < n) r = i + 1;
      return r;
   endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result bundle between the operand source and the serial subtractor.
interface serial_subtractor_if #(parameter int WIDTH = 4);

   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             bout;
   logic             ovf;

   modport master (
      output start, a, b, bin,
      input  busy, done, diff, bout, ovf
   );

   modport slave (
      input  start, a, b, bin,
      output busy, done, diff, bout, ovf
   );

endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// Single-bit full subtractor cell: d = a - b - bin, with borrow out.
module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A - B - bin, LSB first, one bit per clock.
// Define SERIAL_SUB_OVF_EN to compute the signed overflow flag.
module serial_subtractor
   import serial_arith_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   serial_subtractor_if.slave bus
);

   localparam int CW = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);

   state_t           state;
   state_t           state_nxt;
   logic             start_q;
   logic             req;
   logic             last;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] r_sh;
   logic             borrow;
   logic             fs_d;
   logic             fs_bout;
   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] diff_q;
   logic             bout_q;

   assign req  = bus.start & ~start_q;
   assign last = (cnt == CW'(WIDTH - 1));

   full_subtractor u_fs (
      .a    (a_sh[0]),
      .b    (b_sh[0]),
      .bin  (borrow),
      .d    (fs_d),
      .bout (fs_bout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE:  if (req)  state_nxt = ST_SHIFT;
         ST_SHIFT: if (last) state_nxt = ST_DONE;
         ST_DONE:            state_nxt = ST_IDLE;
         default:            state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         start_q <= 1'b0;
         cnt     <= '0;
         a_sh    <= '0;
         b_sh    <= '0;
         r_sh    <= '0;
         borrow  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         diff_q  <= '0;
         bout_q  <= 1'b0;
      end else begin
         start_q <= bus.start;
         done_q  <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (req) begin
                  a_sh   <= bus.a;
                  b_sh   <= bus.b;
                  borrow <= bus.bin;
                  cnt    <= '0;
                  busy_q <= 1'b1;
               end
            end
            ST_SHIFT: begin
               a_sh   <= a_sh >> 1;
               b_sh   <= b_sh >> 1;
               r_sh   <= {fs_d, r_sh[WIDTH-1:1]};
               borrow <= fs_bout;
               cnt    <= cnt + 1'b1;
            end
            ST_DONE: begin
               diff_q <= r_sh;
               bout_q <= borrow;
               done_q <= 1'b1;
               busy_q <= 1'b0;
            end
            default: ;
         endcase
      end
   end

`ifdef SERIAL_SUB_OVF_EN
   // Operand MSBs are shifted out of a_sh/b_sh, so keep them aside.
   logic a_msb;
   logic b_msb;
   logic ovf_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_msb <= 1'b0;
         b_msb <= 1'b0;
         ovf_q <= 1'b0;
      end else begin
         if (state == ST_IDLE && req) begin
            a_msb <= bus.a[WIDTH-1];
            b_msb <= bus.b[WIDTH-1];
         end
         if (state == ST_DONE)
            ovf_q <= (a_msb != b_msb) & (r_sh[WIDTH-1] != a_msb);
      end
   end

   assign bus.ovf = ovf_q;
`else
   assign bus.ovf = 1'b0;
`endif

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.diff = diff_q;
   assign bus.bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor with a cycle-level reference model.
module tb_serial_subtractor;

   localparam int W = 4;
`ifdef SERIAL_SUB_OVF_EN
   localparam bit OVF_ON = 1'b1;
`else
   localparam bit OVF_ON = 1'b0;
`endif

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;
   bit   chk_en;

   serial_subtractor_if #(.WIDTH(W)) bus ();

   serial_subtractor #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: counts cycles from the accepted request.
   int           mcyc;
   int           done_at;
   bit           pend;
   bit           start_qm;
   int           cap_a, cap_b, cap_bin;
   logic [W-1:0] exp_diff;
   logic         exp_bout, exp_ovf, exp_done, exp_busy;

   always @(posedge clk or negedge rst_n) begin : model
      logic [W-1:0] d;
      if (!rst_n) begin
         pend     <= 1'b0;
         start_qm <= 1'b0;
         exp_diff <= '0;
         exp_bout <= 1'b0;
         exp_ovf  <= 1'b0;
         exp_done <= 1'b0;
         exp_busy <= 1'b0;
         done_at  <= 0;
      end else begin
         d = W'(cap_a - cap_b - cap_bin);
         exp_done <= 1'b0;
         if (pend && mcyc == done_at) begin
            exp_diff <= d;
            exp_bout <= (cap_a < cap_b + cap_bin);
            exp_ovf  <= OVF_ON &&
                        (cap_a[W-1] != cap_b[W-1]) && (d[W-1] != cap_a[W-1]);
            exp_done <= 1'b1;
            exp_busy <= 1'b0;
            pend     <= 1'b0;
         end else if (!pend && bus.start && !start_qm) begin
            cap_a   <= int'(bus.a);
            cap_b   <= int'(bus.b);
            cap_bin <= int'(bus.bin);
            pend    <= 1'b1;
            done_at <= mcyc + W + 1;
            exp_busy <= 1'b1;
         end
         start_qm <= bus.start;
      end
   end

   always @(posedge clk) mcyc <= mcyc + 1;

   task automatic chk(input string nm, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("cyc_done", int'(bus.done), int'(exp_done));
         chk("cyc_busy", int'(bus.busy), int'(exp_busy));
         chk("cyc_diff", int'(bus.diff), int'(exp_diff));
         chk("cyc_bout", int'(bus.bout), int'(exp_bout));
         chk("cyc_ovf",  int'(bus.ovf),  int'(exp_ovf));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input string nm, output int lat);
      lat = -1;
      for (int n = 1; n <= 20; n++) begin
         tick();
         if (bus.done) begin
            lat = n;
            break;
         end
      end
      if (lat < 0) chk({nm, "_timeout"}, 0, 1);
   endtask

   task automatic run_op(input string nm, input int a, input int b, input int bi,
                         input int ed, input int eb, input int eo);
      int lat;
      bus.start = 1'b1;
      bus.a     = W'(a);
      bus.b     = W'(b);
      bus.bin   = bi[0];
      tick();
      bus.start = 1'b0;
      wait_done(nm, lat);
      chk({nm, "_lat"},  lat, W + 1);
      chk({nm, "_diff"}, int'(bus.diff), ed);
      chk({nm, "_bout"}, int'(bus.bout), eb);
      chk({nm, "_ovf"},  int'(bus.ovf), OVF_ON ? eo : 0);
   endtask

   int ndone;
   int lat;
   int bcnt;

   initial begin
      checks    = 0;
      failures  = 0;
      chk_en    = 1'b0;
      mcyc      = 0;
      cap_a     = 0;
      cap_b     = 0;
      cap_bin   = 0;
      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      bus.bin   = 1'b0;
      tick();
      tick();
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_diff", int'(bus.diff), 0);
      rst_n  = 1'b1;
      chk_en = 1'b1;
      tick();

      // Basic subtract with busy duration check.
      bus.start = 1'b1;
      bus.a = 4'd9;
      bus.b = 4'd3;
      bus.bin = 1'b0;
      tick();
      bus.start = 1'b0;
      bcnt = 0;
      lat  = -1;
      for (int n = 1; n <= 20; n++) begin
         if (bus.busy) bcnt++;
         tick();
         if (bus.done) begin
            lat = n;
            break;
         end
      end
      chk("basic_lat", lat, 5);
      chk("basic_busy_cycles", bcnt, 5);
      chk("basic_diff", int'(bus.diff), 6);
      chk("basic_bout", int'(bus.bout), 0);
      chk("basic_ovf", int'(bus.ovf), OVF_ON ? 1 : 0);
      tick();

      run_op("uborrow", 3, 9, 0, 4'hA, 1, 1);
      tick();
      run_op("binchain", 0, 0, 1, 4'hF, 1, 0);
      tick();
      run_op("ovf8m1", 8, 1, 0, 7, 0, 1);

      // Back-to-back: second request on the first cycle back in IDLE.
      run_op("b2b", 15, 15, 1, 4'hF, 1, 0);
      tick();

      // Held start yields one operation.
      bus.start = 1'b1;
      bus.a = 4'd5;
      bus.b = 4'd2;
      bus.bin = 1'b0;
      ndone = 0;
      for (int n = 0; n < 20; n++) begin
         tick();
         if (bus.done) ndone++;
      end
      bus.start = 1'b0;
      chk("held_ndone", ndone, 1);
      chk("held_diff", int'(bus.diff), 3);
      tick();

      // Second rising edge and operand change while busy.
      bus.start = 1'b1;
      bus.a = 4'd12;
      bus.b = 4'd4;
      bus.bin = 1'b0;
      tick();
      bus.start = 1'b0;
      bus.a = 4'd1;
      bus.b = 4'd1;
      bus.bin = 1'b1;
      tick();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      wait_done("reedge", lat);
      chk("reedge_lat", lat, W - 1);
      chk("reedge_diff", int'(bus.diff), 8);
      chk("reedge_bout", int'(bus.bout), 0);
      ndone = 0;
      for (int n = 0; n < 10; n++) begin
         tick();
         if (bus.done) ndone++;
      end
      chk("reedge_extra_done", ndone, 0);

      // Reset mid-operation.
      bus.start = 1'b1;
      bus.a = 4'd7;
      bus.b = 4'd2;
      tick();
      bus.start = 1'b0;
      tick();
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", int'(bus.busy), 0);
      chk("midrst_diff", int'(bus.diff), 0);
      chk("midrst_bout", int'(bus.bout), 0);
      tick();
      tick();
      rst_n = 1'b1;
      ndone = 0;
      for (int n = 0; n < 10; n++) begin
         tick();
         if (bus.done) ndone++;
      end
      chk("midrst_no_done", ndone, 0);
      run_op("after_rst", 10, 4, 0, 6, 0, 1);
      tick();
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
